// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// big-endian lane mapping helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t RD   = 3'd1;
    localparam state_t RMW  = 3'd2;
    localparam state_t WR   = 3'd3;
    localparam state_t RESP = 3'd4;

    // Byte offset within the word; offset 0 is the most significant lane.
    localparam logic [1:0] OFF_B0 = 2'd0;
    localparam logic [1:0] OFF_B1 = 2'd1;
    localparam logic [1:0] OFF_B2 = 2'd2;
    localparam logic [1:0] OFF_B3 = 2'd3;

    function automatic logic [1:0] lane_of(input logic [1:0] offset);
        return OFF_B3 - offset;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake plus RAM data port of the load/store unit.
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_store_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]           req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [31:0]           mem_wdata_o;
    logic [31:0]           mem_rdata_i;

    modport slave (
        input  req_valid_i, req_store_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, rsp_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_store_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, rsp_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_align.sv
// Stateless lane logic: misalignment check, big-endian load extract with
// sign/zero extension, and sub-word store merge into the read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign misaligned = (size == SZ_RSVD)
                     || ((size == SZ_HALF) && offset[0])
                     || ((size == SZ_WORD) && (offset != OFF_B0));

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic byte_hit;
        logic half_hit;
        logic [7:0] src;

        assign lane_byte[gi] = rdata[8*gi +: 8];
        assign byte_hit = (size == SZ_BYTE) && (lane_of(offset) == 2'(gi));
        // Upper halfword (offset 0) covers lanes 3..2, lower (offset 2) lanes 1..0.
        assign half_hit = (size == SZ_HALF) && (offset[1] == ((gi < 2) ? 1'b1 : 1'b0));
        assign src      = (size == SZ_HALF) ? wdata[8*(gi%2) +: 8] : wdata[7:0];
        assign merged[8*gi +: 8] = (byte_hit || half_hit) ? src : rdata[8*gi +: 8];
    end

    assign byte_sel = lane_byte[lane_of(offset)];
    assign half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the big-endian word RAM port: one request at a
// time, read-modify-write for sub-word stores, errors answered without access.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mem_lsu_if.slave  bus
);

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    logic        idle;
    logic        misaligned;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign idle = (state_reg == IDLE);

    // In IDLE the checker looks at the live request; afterwards at the captured one.
    lsu_align u_align (
        .offset      (idle ? bus.req_addr_i[1:0] : addr_reg[1:0]),
        .size        (idle ? bus.req_size_i : size_reg),
        .is_unsigned (unsigned_reg),
        .rdata       (bus.mem_rdata_i),
        .wdata       (wdata_reg[15:0]),
        .misaligned  (misaligned),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            size_reg     <= SZ_BYTE;
            unsigned_reg <= 1'b0;
            err_reg      <= 1'b0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_reg     <= bus.req_addr_i;
                        size_reg     <= bus.req_size_i;
                        unsigned_reg <= bus.req_unsigned_i;
                        err_reg      <= misaligned;
                        wdata_reg    <= bus.req_wdata_i;
                        rdata_reg    <= '0;
                        if (misaligned)
                            state_reg <= RESP;
                        else if (!bus.req_store_i)
                            state_reg <= RD;
                        else if (bus.req_size_i == SZ_WORD)
                            state_reg <= WR;
                        else
                            state_reg <= RMW;
                    end
                end
                RD: begin
                    rdata_reg <= load_data;
                    state_reg <= RESP;
                end
                RMW: begin
                    wdata_reg <= merged;
                    state_reg <= WR;
                end
                WR:   state_reg <= RESP;
                RESP: if (bus.rsp_ready_i) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = idle;
    assign bus.rsp_valid_o = (state_reg == RESP);
    assign bus.rsp_err_o   = (state_reg == RESP) && err_reg;
    assign bus.rsp_rdata_o = (state_reg == RESP) ? rdata_reg : '0;
    assign bus.mem_we_o    = (state_reg == WR);
    assign bus.mem_wdata_o = (state_reg == WR) ? wdata_reg : '0;
    assign bus.mem_addr_o  = (state_reg == RD || state_reg == RMW || state_reg == WR)
                           ? {addr_reg[ADDR_WIDTH-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a transaction-level big-endian memory model.
module tb_mem_lsu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_lsu_if #(.ADDR_WIDTH(32)) bus ();

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic        ram_init;
    int          we_pulses;
    int          checks;
    int          errors;
    int          txn_no;
    logic [31:0] last_rdata;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h01010101) ^ 32'hA5C30F96;
    endfunction

    assign bus.mem_rdata_i = ram[bus.mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.mem_we_o) begin
            ram[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
            we_pulses <= we_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble_req();
        bus.req_store_i    = 1'($urandom);
        bus.req_size_i     = 2'($urandom);
        bus.req_unsigned_i = 1'($urandom);
        bus.req_addr_i     = 32'($urandom_range(0, 1023));
        bus.req_wdata_i    = $urandom;
    endtask

    task automatic run_txn(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input int hold);
        int          idx, off, nbytes, sh;
        logic [31:0] word, v, mask, aligned;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_wc, lat, wc, we0;
        logic [31:0] w_addr, rd_hold;

        // Reference: memory seen as a big-endian byte array.
        idx     = int'(addr[9:2]);
        off     = int'(addr[1:0]);
        aligned = {addr[31:2], 2'b00};
        word    = ref_mem[idx];
        e_err   = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        e_rd    = 32'h0;
        e_wc    = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!st) begin
            e_lat = 2;
            case (sz)
                2'd0: begin
                    v = (word >> (8 * (3 - off))) & 32'hFF;
                    if (!uns && v >= 32'd128) v = v - 32'd256;
                end
                2'd1: begin
                    v = (word >> (8 * (2 - off))) & 32'hFFFF;
                    if (!uns && v >= 32'd32768) v = v - 32'd65536;
                end
                default: v = word;
            endcase
            e_rd = v;
        end else begin
            nbytes = 1 << sz;
            sh     = 8 * (4 - off - nbytes);
            mask   = (sz == 2'd2) ? 32'hFFFFFFFF : (((32'h1 << (8 * nbytes)) - 32'h1) << sh);
            ref_mem[idx] = (word & ~mask) | ((wd << sh) & mask);
            e_lat  = (sz == 2'd2) ? 2 : 3;
            e_wc   = (sz == 2'd2) ? 1 : 2;
        end

        @(negedge clk);
        check("req_ready_idle", {31'h0, bus.req_ready_o}, 32'h1);
        bus.req_valid_i    = 1'b1;
        bus.req_store_i    = st;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wd;
        bus.rsp_ready_i    = 1'b0;
        we0 = we_pulses;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        scramble_req();

        lat = 0;
        wc  = 0;
        w_addr = 32'h0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) check("mem_addr_c1", bus.mem_addr_o, e_err ? 32'h0 : aligned);
            if (bus.mem_we_o) begin
                wc = n;
                w_addr = bus.mem_addr_o;
            end
            if (bus.rsp_valid_o) lat = n;
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("we_cycle", 32'(wc), 32'(e_wc));
        if (wc != 0) check("we_addr", w_addr, aligned);
        check("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, e_err});
        check("rsp_rdata", bus.rsp_rdata_o, e_rd);
        last_rdata = bus.rsp_rdata_o;
        rd_hold    = bus.rsp_rdata_o;

        for (int h = 0; h < hold; h++) begin
            bus.req_valid_i = 1'b1;
            @(negedge clk);
            check("hold_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
            check("hold_rdata", bus.rsp_rdata_o, rd_hold);
            check("hold_ready", {31'h0, bus.req_ready_o}, 32'h0);
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("back_idle", {30'h0, bus.rsp_valid_o, bus.req_ready_o}, 32'h1);
        check("we_pulses", 32'(we_pulses - we0), (e_wc != 0) ? 32'h1 : 32'h0);
        check("ram_word", ram[idx], ref_mem[idx]);
        txn_no++;
        $display("txn %0d: st=%0d sz=%0d u=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d hold=%0d",
                 txn_no, st, sz, uns, addr, wd, e_err, last_rdata, lat, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'h0, bus.req_ready_o}, 32'h1);
        check({tag, "_valid"}, {31'h0, bus.rsp_valid_o}, 32'h0);
        check({tag, "_err"},   {31'h0, bus.rsp_err_o}, 32'h0);
        check({tag, "_rdata"}, bus.rsp_rdata_o, 32'h0);
        check({tag, "_we"},    {31'h0, bus.mem_we_o}, 32'h0);
        check({tag, "_addr"},  bus.mem_addr_o, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata_o, 32'h0);
    endtask

    initial begin
        logic [31:0] old_word;
        int          we0;

        checks = 0;
        errors = 0;
        txn_no = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst_n = 1'b0;
        ram_init = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        scramble_req();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        ram_init = 1'b0;
        rst_n = 1'b1;

        // Big-endian loads with sign/zero extension.
        run_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF7F01, 0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 0);
        check("tp_lb", last_rdata, 32'hFFFFFF80);
        run_txn(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 0);
        check("tp_lbu", last_rdata, 32'h00000080);
        run_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0);
        check("tp_lh102", last_rdata, 32'h00007F01);
        run_txn(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 0);
        check("tp_lh100", last_rdata, 32'hFFFF80FF);

        // Read-modify-write of sub-word stores.
        run_txn(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h201, 32'h000000AB, 0);
        check("tp_sb", ram[8'h80], 32'h11AB3344);
        run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 0);
        check("tp_sh", ram[8'h80], 32'h11ABBEEF);

        run_txn(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0);
        check("tp_lw", last_rdata, 32'hDEADBEEF);

        // Errors and a stalled response with requests presented meanwhile.
        run_txn(1'b1, 2'd1, 1'b0, 32'h203, 32'h12345678, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h302, 32'h0, 0);
        run_txn(1'b1, 2'd3, 1'b0, 32'h200, 32'hCAFEF00D, 2);
        run_txn(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 5);

        // Reset while the byte store is in its merge cycle.
        old_word = ref_mem[8'h80];
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_store_i    = 1'b1;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h201;
        bus.req_wdata_i    = 32'h000000CD;
        we0 = we_pulses;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("rmw_addr", bus.mem_addr_o, 32'h200);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_write", 32'(we_pulses - we0), 32'h0);
        check("midrst_ram", ram[8'h80], old_word);
        check("midrst_no_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
        $display("txn reset-abort: sb addr=00000201 aborted in merge cycle");

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            a = {22'h0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom);
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
